// File: rtl/mixcolumns_engine.sv
// Iterative AES MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns per clock, valid/ready on both sides.
// Optional macro MIXCOL_BYPASS_EN adds a bypass port that passes a state through unmixed (AES final round).
module mixcolumns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
`ifdef MIXCOL_BYPASS_EN
  ,
  input  logic         bypass
`endif
);

  localparam int NB = 4 / COLS_PER_CYCLE;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("mixcolumns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic            inv_q, inv_d;
  logic [127:0]    work_q, work_d;
  logic            accept;
  logic [1:0]      col_idx;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r of the column lives at bits [8*(3-r) +: 8]; every product is built from an xtime chain.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv_mode);
    logic [7:0]  a  [4];
    logic [7:0]  p2 [4];
    logic [7:0]  p4 [4];
    logic [7:0]  p8 [4];
    logic [31:0] res;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[8*(3-r) +: 8];
      p2[r] = xtime(a[r]);
      p4[r] = xtime(p2[r]);
      p8[r] = xtime(p4[r]);
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      if (inv_mode) begin
        res[8*(3-r) +: 8] = (p8[r] ^ p4[r] ^ p2[r])
                          ^ (p8[(r+1)%4] ^ p2[(r+1)%4] ^ a[(r+1)%4])
                          ^ (p8[(r+2)%4] ^ p4[(r+2)%4] ^ a[(r+2)%4])
                          ^ (p8[(r+3)%4] ^ a[(r+3)%4]);
      end else begin
        res[8*(3-r) +: 8] = p2[r]
                          ^ (p2[(r+1)%4] ^ a[(r+1)%4])
                          ^ a[(r+2)%4]
                          ^ a[(r+3)%4];
      end
    end
    return res;
  endfunction

  assign in_ready  = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign out_valid = (state_q == DONE);
  assign state_out = work_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    beat_d  = beat_q;
    inv_d   = inv_q;
    work_d  = work_q;
    col_idx = '0;
    accept  = in_valid & in_ready;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          work_d  = state_in;
          inv_d   = inv;
          beat_d  = '0;
          state_d = BUSY;
`ifdef MIXCOL_BYPASS_EN
          if (bypass) state_d = DONE;
`endif
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          col_idx = 2'(int'(beat_q) * COLS_PER_CYCLE + k);
          work_d[{col_idx, 5'd0} +: 32] = mix_col(work_q[{col_idx, 5'd0} +: 32], inv_q);
        end
        if (beat_q == LAST_BEAT) begin
          state_d = DONE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      inv_q   <= 1'b0;
      // NOTE: the working register is reset so an aborted transaction leaves state_out at zero.
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      inv_q   <= inv_d;
      work_q  <= work_d;
    end
  end

endmodule

// File: doc/mixcolumns_engine.md
# mixcolumns_engine

Parametrised, iterative AES MixColumns / InvMixColumns unit with a valid/ready handshake on both sides. It accepts one 128-bit state, transforms it `COLS_PER_CYCLE` columns per clock, and holds the result until the downstream stage takes it. Forward or inverse mode is selected per transaction. It serves both the transmitter round datapath (forward) and the receiver round datapath (inverse), replacing the purely combinational inverse-only mixer.

## Interface
- `COLS_PER_CYCLE`, default 1: columns transformed per clock. Legal values are 1, 2 and 4; any other value is a static elaboration error.
- `clk`  input  1  — clock; all state updates on rising edge.
- `rst`  input  1  — asynchronous, active-high reset.
- `in_valid`  input  1  — `state_in` and `inv` valid.
- `in_ready`  output  1  — engine can accept a state this cycle.
- `state_in`  input  128  — column c = bits [c*32+:32]; row r byte of column c = bits [c*32+24-8r+:8].
- `inv`  input  1  — 1 = InvMixColumns, 0 = MixColumns; sampled at accept.
- `out_valid`  output  1  — `state_out` holds a finished result.
- `out_ready`  input  1  — downstream accepts `state_out`.
- `state_out`  output  128  — result, same byte layout as `state_in`.
- `bypass`  input  1  — only with `MIXCOL_BYPASS_EN` (see Configuration).

## Operation
- The FSM has three states:
  - `IDLE`: `in_ready`=1. Accept (`in_valid & in_ready`) loads the working register and latches `inv`, then moves to `BUSY` with beat counter = 0.
  - `BUSY`: each edge replaces columns [b*CPC .. b*CPC+CPC-1] in the working register, where CPC = `COLS_PER_CYCLE` and b = beat counter. After NB = 4/CPC beats, go to `DONE`.
  - `DONE`: `out_valid`=1 and `state_out` = working register, held stable while `out_ready`=0.
    - `out_ready`=1 with no new accept: go to `IDLE`.
    - `out_ready`=1 with `in_valid`=1: take the new state and go directly to `BUSY`.
- `in_ready` = (state==`IDLE`) | (state==`DONE` & `out_ready`).
- Beat counter: width ceil(log2(NB)), minimum 1 bit. When NB=1 it does not wrap; the FSM leaves `BUSY` after a single beat.
- Forward matrix rows are {02 03 01 01} rotated per row. Inverse matrix rows are {0e 0b 0d 09} rotated per row.
- GF(2^8) reduction polynomial is 0x11b. Multiplication uses xtime chains: no tables, no multipliers.
- Inputs other than `in_valid`/`state_in`/`inv` are ignored outside accept cycles. Changing `inv` mid-transaction has no effect.
- Reset:
  - Outputs: `in_ready`=0 while `rst`=1, then 1 in the first cycle after release. `out_valid`=0, `state_out`=0.
  - Internal state: FSM=`IDLE`, counter=0, latched mode=0.
  - Reset asserted in `BUSY` or `DONE` aborts the transaction and drops the result, with no output pulse.

## Timing
- Latency: a state accepted at edge k gives `out_valid`=1 in the cycle after edge k+NB. That is 4, 2 or 1 cycles of processing for CPC 1, 2 or 4.
- Throughput is back-to-back under continuous `out_ready`: one state per NB+1 cycles, since the `DONE` cycle overlaps the next accept.
- Datapath critical path: one column mix (CPC copies) plus the mux into the working register. There is no combinational path from `state_in` to `state_out`.
- `out_valid` never deasserts without a handshake (or reset).

## Configuration
- Macro: `MIXCOL_BYPASS_EN`.
- Defined:
  - The `bypass` port exists and is latched at accept.
  - A bypassed transaction skips `BUSY`: `IDLE`→`DONE` in one edge, with `state_out` = `state_in` unmodified. This is used for the AES final round, which omits MixColumns.
  - Mode `inv` is ignored when bypassed.
- Undefined: the port is absent, and every transaction runs NB beats.

## Test plan
- Forward, CPC=1: column 0 = db135345, others 01010101 → column 0 = 8e4da1bc, others 01010101. `out_valid` rises 4 cycles after accept.
- Inverse, CPC=2: column 1 = 8e4da1bc, column 2 = 9fdc589d, others c6c6c6c6 → column 1 = db135345, column 2 = f20a225c, c6 columns unchanged. Latency 2.
- Round trip, CPC=4: 1000 random states, forward then inverse → identity. Accepts are back-to-back with `out_ready` held 1, one result every 2 cycles.
- Backpressure: hold `out_ready`=0 for 5 cycles in `DONE` → `state_out` stable, `in_ready`=0. Release with `in_valid`=1 → old result and new accept complete on the same edge.
- Reset mid-`BUSY` (beat 2, CPC=1) → `out_valid`=0 and `state_out`=0 at once. The next accept produces a correct, uncorrupted result.
- With `MIXCOL_BYPASS_EN`: `bypass`=1, `state_in`=00112233445566778899aabbccddeeff → same value out with `out_valid` 1 cycle after accept.
